// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM state codes and requester IDs.
package dmem_arb_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_ACCESS = ST_ACCESS,
      S_DONE   = ST_DONE
   } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin winner select with a per-port exclude mask.
module rr_arbiter_2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   input  logic [1:0] i_exclude,
   output logic       o_winner,
   output logic       o_valid
);

   logic [1:0] w_req;

   assign w_req   = i_req & ~i_exclude;
   assign o_valid = |w_req;

   always_comb begin
      o_winner = PORT_CPU;
      if (w_req == 2'b11) begin
         o_winner = ~i_last_grant;
      end else if (w_req[1]) begin
         o_winner = PORT_DMA;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer between a CPU port and a DMA port in front of datamemory.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_ack,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_ack,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_in,
   input  logic [DATA_WIDTH-1:0] mem_out,
   output logic                  busy
);

   state_t                r_state, w_state_nxt;
   logic                  r_grant, r_last_grant, r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  w_win, w_valid, w_load, w_done;
   logic [1:0]            w_excl;
   logic [DATA_WIDTH-1:0] w_rd;

   // The port being acked in DONE must not win again off its still-high req.
   assign w_excl = (r_state == S_DONE) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;

   rr_arbiter_2 u_rr (
      .i_req       ({m1_req, m0_req}),
      .i_last_grant(r_last_grant),
      .i_exclude   (w_excl),
      .o_winner    (w_win),
      .o_valid     (w_valid)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_valid) begin
               w_state_nxt = S_ACCESS;
               w_load      = 1'b1;
            end
         end
         S_ACCESS: w_state_nxt = S_DONE;
         S_DONE: begin
            if (w_valid) begin
               w_state_nxt = S_ACCESS;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Request fields are latched at grant so a dropped req still completes cleanly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_grant      <= PORT_CPU;
         r_last_grant <= PORT_DMA;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_grant <= w_win;
            r_we    <= w_win ? m1_we : m0_we;
            r_addr  <= w_win ? m1_addr : m0_addr;
            r_wdata <= w_win ? m1_wdata : m0_wdata;
         end
         if (r_state == S_DONE) begin
            r_last_grant <= r_grant;
         end
      end
   end

   assign w_done      = (r_state == S_DONE);
   assign m0_ack      = w_done & ~r_grant;
   assign m1_ack      = w_done & r_grant;
   assign w_rd        = (w_done && !r_we) ? mem_out : '0;
   assign m0_rdata    = m0_ack ? w_rd : '0;
   assign m1_rdata    = m1_ack ? w_rd : '0;
   assign mem_we      = (r_state == S_ACCESS) & r_we;
   assign mem_address = r_addr;
   assign mem_in      = r_wdata;
   assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural registered-read data memory.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tb_init = 1'b1;
   logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [9:0]  m0_addr = 0, m1_addr = 0;
   logic [31:0] m0_wdata = 0, m1_wdata = 0;
   logic        m0_ack, m1_ack, mem_we, busy;
   logic [31:0] m0_rdata, m1_rdata, mem_in;
   logic [31:0] mem_out;
   logic [9:0]  mem_address;

   logic [31:0] mem [0:1023];

   typedef struct {
      logic        p;
      logic [31:0] d;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   int          checks = 0;
   int          errors = 0;
   int          we_cnt = 0;
   int          busy_cnt = 0;
   logic [9:0]  we_addr = 0;
   int          lat;

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .m0_req     (m0_req),
      .m0_we      (m0_we),
      .m0_addr    (m0_addr),
      .m0_wdata   (m0_wdata),
      .m0_ack     (m0_ack),
      .m0_rdata   (m0_rdata),
      .m1_req     (m1_req),
      .m1_we      (m1_we),
      .m1_addr    (m1_addr),
      .m1_wdata   (m1_wdata),
      .m1_ack     (m1_ack),
      .m1_rdata   (m1_rdata),
      .mem_address(mem_address),
      .mem_we     (mem_we),
      .mem_in     (mem_in),
      .mem_out    (mem_out),
      .busy       (busy)
   );

   always @(posedge clk) begin
      if (tb_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
         mem[0] <= 32'h0000_0011;
         mem[1] <= 32'h0000_0022;
         mem[3] <= 32'h0000_00AA;
      end else if (mem_we) begin
         mem[mem_address] <= mem_in;
      end
      mem_out <= mem[mem_address];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every ack.
   always @(negedge clk) begin
      if (mem_we) begin
         we_cnt++;
         we_addr = mem_address;
      end
      if (busy) busy_cnt++;
      if (m0_ack || m1_ack) begin
         chk("dual_ack", 32'(m0_ack & m1_ack), 32'h0);
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got m0=%b m1=%b expected none", m0_ack, m1_ack);
         end else begin
            e = q.pop_front();
            chk("ack_port", 32'(m1_ack), 32'(e.p));
            chk("ack_rdata", e.p ? m1_rdata : m0_rdata, e.d);
            chk("other_rdata", e.p ? m0_rdata : m1_rdata, 32'h0);
         end
      end
   end

   task automatic access(input logic p, input logic we, input logic [9:0] a,
                         input logic [31:0] d, output int n);
      n = 0;
      @(posedge clk);
      #1;
      if (p) begin
         m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d;
      end else begin
         m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d;
      end
      do begin
         @(negedge clk);
         n++;
      end while (!(p ? m1_ack : m0_ack) && n < 20);
      if (!(p ? m1_ack : m0_ack)) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: port %0d got no ack, expected one within 20 cycles", p);
      end
   endtask

   task automatic drop(input logic p);
      @(posedge clk);
      #1;
      if (p) m1_req = 0;
      else m0_req = 0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   function automatic exp_t mk(input logic p, input logic [31:0] d);
      exp_t x;
      x.p = p;
      x.d = d;
      return x;
   endfunction

   initial begin
      int l0, l1;
      #1;
      chk("rst_m0_ack", 32'(m0_ack), 0);
      chk("rst_m1_ack", 32'(m1_ack), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mem_address", 32'(mem_address), 0);
      chk("rst_mem_in", mem_in, 0);
      repeat (2) @(posedge clk);
      #1 tb_init = 0;
      rst = 0;

      // Single read
      we_cnt = 0;
      q.push_back(mk(1'b0, 32'h0000_00AA));
      access(1'b0, 1'b0, 10'h3, 32'h0, lat);
      chk("read_latency", 32'(lat), 3);
      drop(1'b0);
      chk("read_no_we", 32'(we_cnt), 0);

      // Single write then read
      we_cnt = 0;
      q.push_back(mk(1'b1, 32'h0));
      access(1'b1, 1'b1, 10'h1F, 32'hDEAD_BEEF, lat);
      drop(1'b1);
      chk("write_we_cycles", 32'(we_cnt), 1);
      chk("write_we_addr", 32'(we_addr), 32'h1F);
      q.push_back(mk(1'b0, 32'hDEAD_BEEF));
      access(1'b0, 1'b0, 10'h1F, 32'h0, lat);
      drop(1'b0);

      // Contention from reset
      do_reset();
      busy_cnt = 0;
      q.push_back(mk(1'b0, 32'h0000_0011));
      q.push_back(mk(1'b1, 32'h0000_0022));
      fork
         begin access(1'b0, 1'b0, 10'h0, 32'h0, l0); drop(1'b0); end
         begin access(1'b1, 1'b0, 10'h1, 32'h0, l1); drop(1'b1); end
      join
      repeat (3) @(negedge clk);
      chk("cont_lat0", 32'(l0), 3);
      chk("cont_lat1", 32'(l1), 5);
      chk("cont_busy_cycles", 32'(busy_cnt), 4);

      // Fairness: both hold req for 8 accesses
      for (int i = 0; i < 4; i++) begin
         q.push_back(mk(1'b0, 32'h0000_00AA));
         q.push_back(mk(1'b1, 32'hDEAD_BEEF));
      end
      fork
         begin
            for (int i = 0; i < 4; i++) access(1'b0, 1'b0, 10'h3, 32'h0, l0);
            drop(1'b0);
         end
         begin
            for (int j = 0; j < 4; j++) access(1'b1, 1'b0, 10'h1F, 32'h0, l1);
            drop(1'b1);
         end
      join
      repeat (2) @(negedge clk);
      chk("fair_drained", 32'(q.size()), 0);

      // Write-read hazard; last grant was port 1 so the write goes first
      q.push_back(mk(1'b0, 32'h0));
      q.push_back(mk(1'b1, 32'h0000_1234));
      fork
         begin access(1'b0, 1'b1, 10'h5, 32'h0000_1234, l0); drop(1'b0); end
         begin access(1'b1, 1'b0, 10'h5, 32'h0, l1); drop(1'b1); end
      join

      // Reset mid-write
      @(posedge clk);
      #1;
      m1_req = 1; m1_we = 1; m1_addr = 10'h7; m1_wdata = 32'h55;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_we_before", 32'(mem_we), 1);
      #1 rst = 1;
      m1_req = 0;
      #1;
      chk("midrst_we_after", 32'(mem_we), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_ack", 32'(m1_ack), 0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      q.push_back(mk(1'b0, 32'h0));
      access(1'b0, 1'b0, 10'h7, 32'h0, lat);
      drop(1'b0);
      repeat (3) @(negedge clk);
      chk("final_idle", 32'(busy), 0);
      chk("scoreboard_empty", 32'(q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
      $fatal(1);
   end

endmodule
